// File: rtl/ascii_pkg.sv
// ascii_pkg: character constants, decoder state encoding and byte-class helpers shared by
// the ASCII command decoder and the hex2ascii encoder side.
package ascii_pkg;

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;
   localparam logic [7:0] CH_U  = 8'h55;
   localparam logic [7:0] CH_D  = 8'h44;
   localparam logic [7:0] CH_L  = 8'h4C;
   localparam logic [7:0] CH_R  = 8'h52;
   localparam logic [7:0] CH_T  = 8'h54;

   typedef enum logic [1:0] {S_IDLE, S_BTN, S_TIME, S_ERR} state_t;
   typedef enum logic [1:0] {B_U, B_D, B_L, B_R} btn_t;

   function automatic logic is_term(input logic [7:0] c);
      return c == CH_LF || c == CH_CR;
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return c >= CH_0 && c <= CH_9;
   endfunction

   function automatic logic is_btn(input logic [7:0] c);
      return c == CH_U || c == CH_D || c == CH_L || c == CH_R;
   endfunction

   function automatic btn_t btn_code(input logic [7:0] c);
      return c == CH_U ? B_U : c == CH_D ? B_D : c == CH_L ? B_L : B_R;
   endfunction

endpackage

// File: rtl/ascii_cmd_decoder_bcd2_to_bin.sv
// bcd2_to_bin: two BCD digits to a 7-bit binary value plus an upper-bound range check.
module bcd2_to_bin (
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic [6:0] limit,
   output logic [6:0] bin,
   output logic       in_range
);

   always_comb begin
      bin      = 7'(tens * 7'd10) + 7'(ones);
      in_range = bin < limit;
   end

endmodule

// File: rtl/ascii_cmd_decoder.sv
// ascii_cmd_decoder: line-oriented parser turning UART RX bytes into button pulses and a
// "Thhmmss" time-set command. Optional byte echo to UART TX when CMD_ECHO_EN is defined.
module ascii_cmd_decoder
   import ascii_pkg::*;
#(
   parameter int HOUR_LIMIT = 24,
   parameter int MS_LIMIT   = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       tx_busy,
   output logic       btn_u,
   output logic       btn_d,
   output logic       btn_l,
   output logic       btn_r,
   output logic       time_set,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic [5:0] set_sec,
   output logic       cmd_err,
   output logic [7:0] tx_data,
   output logic       tx_start
);

   state_t          state_q, state_d;
   btn_t            btn_sel_q, btn_sel_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [5:0][3:0] slot_q, slot_d;
   logic [3:0]      btn_pulse_q, btn_pulse_d;
   logic            time_set_q, time_set_d;
   logic            cmd_err_q, cmd_err_d;
   logic [4:0]      set_hour_q, set_hour_d;
   logic [5:0]      set_min_q, set_min_d;
   logic [5:0]      set_sec_q, set_sec_d;
   logic [6:0]      hh, mm, ss;
   logic            hh_ok, mm_ok, ss_ok;

   // slot order is h-tens, h-ones, m-tens, m-ones, s-tens, s-ones
   bcd2_to_bin u_hh (.tens(slot_q[0]), .ones(slot_q[1]), .limit(7'(HOUR_LIMIT)), .bin(hh), .in_range(hh_ok));
   bcd2_to_bin u_mm (.tens(slot_q[2]), .ones(slot_q[3]), .limit(7'(MS_LIMIT)),   .bin(mm), .in_range(mm_ok));
   bcd2_to_bin u_ss (.tens(slot_q[4]), .ones(slot_q[5]), .limit(7'(MS_LIMIT)),   .bin(ss), .in_range(ss_ok));

   logic unused_bin_msbs;
   assign unused_bin_msbs = ^{hh[6:5], mm[6], ss[6]};

   always_comb begin
      state_d     = state_q;
      btn_sel_d   = btn_sel_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      btn_pulse_d = '0;
      time_set_d  = 1'b0;
      cmd_err_d   = 1'b0;
      set_hour_d  = set_hour_q;
      set_min_d   = set_min_q;
      set_sec_d   = set_sec_q;
      if (rx_done && rx_data != CH_SP) begin
         case (state_q)
            S_IDLE: begin
               if (is_btn(rx_data)) begin
                  state_d   = S_BTN;
                  btn_sel_d = btn_code(rx_data);
               end else if (rx_data == CH_T) begin
                  state_d = S_TIME;
                  cnt_d   = '0;
               end else if (!is_term(rx_data)) begin
                  state_d = S_ERR;
               end
            end
            S_BTN: begin
               if (is_term(rx_data)) begin
                  btn_pulse_d[btn_sel_q] = 1'b1;
                  state_d                = S_IDLE;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_TIME: begin
               if (is_digit(rx_data) && cnt_q < 3'd6) begin
                  slot_d[cnt_q] = rx_data[3:0];
                  cnt_d         = cnt_q + 3'd1;
               end else if (is_term(rx_data)) begin
                  state_d = S_IDLE;
                  if (cnt_q == 3'd6 && hh_ok && mm_ok && ss_ok) begin
                     time_set_d = 1'b1;
                     set_hour_d = hh[4:0];
                     set_min_d  = mm[5:0];
                     set_sec_d  = ss[5:0];
                  end else begin
                     cmd_err_d = 1'b1;
                  end
               end else begin
                  state_d = S_ERR;
               end
            end
            default: begin
               if (is_term(rx_data)) begin
                  cmd_err_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         btn_sel_q   <= B_U;
         cnt_q       <= '0;
         slot_q      <= '0;
         btn_pulse_q <= '0;
         time_set_q  <= 1'b0;
         cmd_err_q   <= 1'b0;
         set_hour_q  <= '0;
         set_min_q   <= '0;
         set_sec_q   <= '0;
      end else begin
         state_q     <= state_d;
         btn_sel_q   <= btn_sel_d;
         cnt_q       <= cnt_d;
         slot_q      <= slot_d;
         btn_pulse_q <= btn_pulse_d;
         time_set_q  <= time_set_d;
         cmd_err_q   <= cmd_err_d;
         set_hour_q  <= set_hour_d;
         set_min_q   <= set_min_d;
         set_sec_q   <= set_sec_d;
      end
   end

   assign btn_u    = btn_pulse_q[B_U];
   assign btn_d    = btn_pulse_q[B_D];
   assign btn_l    = btn_pulse_q[B_L];
   assign btn_r    = btn_pulse_q[B_R];
   assign time_set = time_set_q;
   assign cmd_err  = cmd_err_q;
   assign set_hour = set_hour_q;
   assign set_min  = set_min_q;
   assign set_sec  = set_sec_q;

`ifdef CMD_ECHO_EN
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_start_q, tx_start_d;
   logic       lf_pend_q, lf_pend_d;

   // a pending LF owns the cycle after its CR; a byte landing then loses its echo
   always_comb begin
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      lf_pend_d  = 1'b0;
      if (lf_pend_q) begin
         tx_start_d = 1'b1;
         tx_data_d  = CH_LF;
      end else if (rx_done && !tx_busy) begin
         tx_start_d = 1'b1;
         tx_data_d  = rx_data == CH_LF ? CH_CR : rx_data;
         lf_pend_d  = rx_data == CH_LF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         lf_pend_q  <= 1'b0;
      end else begin
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         lf_pend_q  <= lf_pend_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
`else
   logic unused_tx_busy;
   assign unused_tx_busy = tx_busy;
   assign tx_data        = '0;
   assign tx_start       = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_cmd_decoder.sv
// tb_ascii_cmd_decoder: directed command lines with hand-computed pulse counts and time values.
module tb_ascii_cmd_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_done = 1'b0;
   logic       tx_busy = 1'b0;
   logic       btn_u, btn_d, btn_l, btn_r, time_set, cmd_err, tx_start;
   logic [4:0] set_hour;
   logic [5:0] set_min, set_sec;
   logic [7:0] tx_data;

   int checks = 0;
   int errors = 0;
   int n_u = 0, n_d = 0, n_l = 0, n_r = 0, n_ts = 0, n_err = 0, n_multi = 0, n_tx = 0;
   int e_u = 0, e_d = 0, e_l = 0, e_r = 0, e_ts = 0, e_err = 0;
   logic [7:0] echo_q[$];

   always #5 clk = ~clk;

   ascii_cmd_decoder dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
      .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .time_set(time_set),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .cmd_err(cmd_err),
      .tx_data(tx_data), .tx_start(tx_start)
   );

   always @(negedge clk) begin
      n_u   <= n_u + int'(btn_u);
      n_d   <= n_d + int'(btn_d);
      n_l   <= n_l + int'(btn_l);
      n_r   <= n_r + int'(btn_r);
      n_ts  <= n_ts + int'(time_set);
      n_err <= n_err + int'(cmd_err);
      n_tx  <= n_tx + int'(tx_start);
      if (int'(btn_u) + int'(btn_d) + int'(btn_l) + int'(btn_r) + int'(time_set) + int'(cmd_err) > 1)
         n_multi <= n_multi + 1;
      if (tx_start) echo_q.push_back(tx_data);
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_line(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         rx_data = s[i];
         rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_counts(input string tag);
      check({tag, " btn_u"}, n_u, e_u);
      check({tag, " btn_d"}, n_d, e_d);
      check({tag, " btn_l"}, n_l, e_l);
      check({tag, " btn_r"}, n_r, e_r);
      check({tag, " time_set"}, n_ts, e_ts);
      check({tag, " cmd_err"}, n_err, e_err);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst btn_u", int'(btn_u), 0);
      check("rst cmd_err", int'(cmd_err), 0);
      check("rst time_set", int'(time_set), 0);
      check("rst set_hour", int'(set_hour), 0);
      check("rst set_min", int'(set_min), 0);
      check("rst set_sec", int'(set_sec), 0);
      check("rst tx_start", int'(tx_start), 0);
      rst = 1'b0;
      @(negedge clk);

      // exact 1-cycle latency after the LF strobe
      rx_data = "U";
      rx_done = 1'b1;
      @(negedge clk);
      rx_data = 8'h0A;
      @(negedge clk);
      rx_done = 1'b0;
      check("U latency btn_u", int'(btn_u), 1);
      check("U latency cmd_err", int'(cmd_err), 0);
      @(negedge clk);
      check("U pulse width", int'(btn_u), 0);
      repeat (3) @(negedge clk);
      e_u++;
      check_counts("U");

      send_line("T235959\r\n");
      e_ts++;
      check_counts("T235959");
      check("T235959 hour", int'(set_hour), 23);
      check("T235959 min", int'(set_min), 59);
      check("T235959 sec", int'(set_sec), 59);

      send_line("T245900\n");
      e_err++;
      check_counts("T245900");
      check("T245900 hour", int'(set_hour), 23);
      check("T245900 min", int'(set_min), 59);

      send_line("T235960\n");
      e_err++;
      check_counts("T235960");
      check("T235960 sec", int'(set_sec), 59);

      send_line("T000000\n");
      e_ts++;
      check_counts("T000000");
      check("T000000 hour", int'(set_hour), 0);

      send_line("T1230\n");
      e_err++;
      check_counts("T1230");
      send_line("T1234567\n");
      e_err++;
      check_counts("T1234567");
      send_line("UX\n");
      e_err++;
      check_counts("UX");
      send_line("u\n");
      e_err++;
      check_counts("lower u");

      send_line("T12");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_line("D\n");
      e_d++;
      check_counts("rst midline");

      send_line(" L \n");
      e_l++;
      check_counts("spaced L");

      send_line("\r\n");
      check_counts("empty line");

      begin
         int base;
         base = echo_q.size();
         send_line("R\n");
         e_r++;
         check_counts("R");
`ifdef CMD_ECHO_EN
         check("echo count", echo_q.size() - base, 3);
         if (echo_q.size() - base == 3) begin
            check("echo R", int'(echo_q[base]), 8'h52);
            check("echo CR", int'(echo_q[base + 1]), 8'h0D);
            check("echo LF", int'(echo_q[base + 2]), 8'h0A);
         end
`else
         check("no echo", n_tx, 0);
`endif
      end

      check("exclusive pulses", n_multi, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
